obstacle_drawer: RTL and testbench
==================================

Name: obstacle_drawer

Overview:
- Per-shape drawing engine that sits directly upstream of the game controller. It is instantiated once per scrolling obstacle.
- When the controller raises this shape's draw_start bit, the block emits one pixel per clock on x/y/colour. When the sweep is complete it raises draw_done, which the controller muxes onto the VGA adapter.
- It scrolls the obstacle left by STEP pixels on each screen-update tick. It reports shape_gone once the obstacle has left the screen, and that output feeds the controller's score sum.

Parameters:
- INIT_X, 11'd152: x of the left edge after reset.
- INIT_Y, 11'd100: y of the top edge; y is fixed.
- WIDTH, 4'd8: obstacle width in pixels; legal range 1..15.
- HEIGHT, 4'd8: obstacle height in pixels; legal range 1..15.
- STEP, 11'd1: pixels moved left per update tick.
- COLOUR, 3'b111: fill colour; erase always uses 3'b000.

Ports:
- clock, input, 1: system clock.
- reset, input, 1: synchronous, active-high; restores the initial position and clears all state.
- draw_start, input, 1: request to render this shape; the controller holds it high until it sees draw_done.
- update_screen, input, 1: one-cycle frame tick; requests a move.
- x, output, 11: pixel x; valid while plotting=1.
- y, output, 11: pixel y; valid while plotting=1.
- colour, output, 3: pixel colour; valid while plotting=1.
- plotting, output, 1: high on cycles that carry a pixel.
- draw_done, output, 1: render complete.
- shape_gone, output, 11: 11'd0 while on screen, 11'd1 once the shape is off screen.

Behaviour:
- Reset values:
  - pos_x=INIT_X, pos_y=INIT_Y.
  - move_pending=0, gone=0, state=IDLE.
  - x=y=0, colour=0, plotting=0, draw_done=0, shape_gone=0.
- All outputs are registered. Reset overrides every other input in the same cycle, including mid-sweep: the FSM returns to IDLE, move_pending and gone are cleared, and nothing further is plotted.
- update_screen sets move_pending=1 in any state. Multiple ticks before the next render saturate to one move. move_pending is cleared on the cycle the FSM enters ERASE. If a tick arrives on that same cycle, set wins and the move is kept for the next render.
- FSM states:
  - IDLE: on draw_start=1:
    - if gone=1, go to DONE;
    - else if move_pending=1, go to ERASE;
    - else go to DRAW.
  - ERASE: sweep col 0..WIDTH-1 (inner) and row 0..HEIGHT-1 (outer), one pixel per cycle. Output x=pos_x+col, y=pos_y+row, colour=000, plotting=1. After the last pixel, go to MOVE.
  - MOVE: one cycle, plotting=0.
    - If pos_x < STEP: set gone=1 and go to DONE.
    - Else: pos_x -= STEP and go to DRAW.
    - No wrap-around; an underflowed value is never used.
  - DRAW: same sweep as ERASE with colour=COLOUR. After the last pixel, go to DONE.
  - DONE: draw_done=1, plotting=0. Stay until draw_start=0, then go to IDLE with draw_done=0.
    - If draw_start is already low on DONE entry, draw_done is high for exactly one cycle.
- Dropping draw_start during ERASE/MOVE/DRAW does not abort the sweep.
- Latency from the draw_start sample in IDLE at cycle 0, with N=WIDTH*HEIGHT:
  - no pending move: pixels on cycles 1..N, draw_done from cycle N+1;
  - pending move: erase on 1..N, MOVE on N+1, draw on N+2..2N+1, draw_done from 2N+2;
  - gone: draw_done from cycle 1.
- Arithmetic: x and y are 11-bit sums of an 11-bit base and a 4-bit counter, zero-extended. They never exceed 11 bits for legal parameters.
- shape_gone = {10'd0, gone}. It is sticky until reset.

Decomposition:
- Shared package game_pkg:
  - colour constants COL_BLACK=3'b000 and COL_WHITE=3'b111;
  - SCREEN_W=160, SCREEN_H=120;
  - coordinate width COORD_W=11;
  - the drawer state encoding IDLE/ERASE/MOVE/DRAW/DONE.
- One sub-module: rect_sweeper.
  - Inputs: start, enable. Outputs: col, row, last.
  - It is a nested col/row counter, reused by the ERASE and DRAW states.

Test Plan:
- Render with no move (WIDTH=HEIGHT=4, INIT_X=152, INIT_Y=100):
  - draw_start held high from cycle 0 → 16 plotting cycles at x 152..155, y 100..103, colour 111, row-major.
  - draw_done=1 at cycle 17; draw_start dropped at cycle 20 → draw_done=0 at cycle 21.
- Render with a move (update_screen pulse, then draw_start) → 16 black pixels at x 152..155, then 16 white pixels at x 151..154; draw_done at cycle 34.
- Double tick: two update_screen pulses before draw_start → only one move; the drawn x range starts at 151.
- Off-screen (INIT_X=0, STEP=1): update_screen, then draw_start → 16 erase pixels, then draw_done with no DRAW pixels; shape_gone=11'd1.
  - A later draw_start → draw_done one cycle later, plotting stays 0.
- Reset mid-DRAW at pixel 5 → next cycle: plotting=0, draw_done=0, state=IDLE; a new render starts at INIT_X.
- Tick collision: update_screen on the cycle IDLE enters ERASE → move_pending=1 after the render; the next render erases and moves again.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the game datapath: screen geometry, colours and the
// obstacle drawer state encoding.
package game_pkg;
  localparam int COORD_W  = 11;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_WHITE = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    ERASE,
    MOVE,
    DRAW,
    DONE
  } drawer_state_t;

  function automatic logic is_sweep(input drawer_state_t s);
    return (s == ERASE) || (s == DRAW);
  endfunction
endpackage

// File: rtl/obstacle_drawer_if.sv
// Controller <-> obstacle drawer link: render request, move tick, pixel stream
// and status back to the controller.
interface obstacle_drawer_if;
  import game_pkg::*;

  logic               draw_start;
  logic               update_screen;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic [2:0]         colour;
  logic               plotting;
  logic               draw_done;
  logic [COORD_W-1:0] shape_gone;

  modport master (
    output draw_start, update_screen,
    input  x, y, colour, plotting, draw_done, shape_gone
  );

  modport slave (
    input  draw_start, update_screen,
    output x, y, colour, plotting, draw_done, shape_gone
  );
endinterface

// File: rtl/rect_sweeper.sv
// Row-major col/row counter over a WIDTH x HEIGHT rectangle. col/row give the
// pixel for the coming cycle so the owner can register it; last flags the
// pixel currently held.
module rect_sweeper #(
  parameter logic [3:0] WIDTH  = 4'd8,
  parameter logic [3:0] HEIGHT = 4'd8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       enable,
  output logic [3:0] col,
  output logic [3:0] row,
  output logic       last
);
  logic [3:0] col_reg, row_reg;
  logic       col_wrap;

  always_comb begin
    col_wrap = (col_reg == WIDTH - 4'd1);
    col      = col_reg;
    row      = row_reg;
    if (start) begin
      col = 4'd0;
      row = 4'd0;
    end else if (enable) begin
      if (col_wrap) begin
        col = 4'd0;
        row = row_reg + 4'd1;
      end else begin
        col = col_reg + 4'd1;
      end
    end
  end

  assign last = col_wrap && (row_reg == HEIGHT - 4'd1);

  always_ff @(posedge clock) begin
    if (reset) begin
      col_reg <= 4'd0;
      row_reg <= 4'd0;
    end else begin
      col_reg <= col;
      row_reg <= row;
    end
  end
endmodule

// File: rtl/obstacle_drawer.sv
// One scrolling obstacle: erases/redraws its rectangle on request, shifts left
// on each frame tick and reports when it has left the screen.
module obstacle_drawer
  import game_pkg::*;
#(
  parameter logic [10:0] INIT_X = 11'd152,
  parameter logic [10:0] INIT_Y = 11'd100,
  parameter logic [3:0]  WIDTH  = 4'd8,
  parameter logic [3:0]  HEIGHT = 4'd8,
  parameter logic [10:0] STEP   = 11'd1,
  parameter logic [2:0]  COLOUR = COL_WHITE
) (
  input  logic             clock,
  input  logic             reset,
  obstacle_drawer_if.slave bus
);
  drawer_state_t      state_reg, state_next;
  logic [COORD_W-1:0] pos_x_reg, pos_x_next;
  logic               move_pending_reg, move_pending_next;
  logic               gone_reg, gone_next;
  logic [COORD_W-1:0] x_reg, y_reg;
  logic [2:0]         colour_reg;
  logic               plotting_reg, draw_done_reg;
  logic               sweep_start, sweep_enable, sweep_last;
  logic [3:0]         sweep_col, sweep_row;

  rect_sweeper #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT)
  ) u_sweeper (
    .clock (clock),
    .reset (reset),
    .start (sweep_start),
    .enable(sweep_enable),
    .col   (sweep_col),
    .row   (sweep_row),
    .last  (sweep_last)
  );

  always_comb begin
    state_next        = state_reg;
    pos_x_next        = pos_x_reg;
    gone_next         = gone_reg;
    move_pending_next = move_pending_reg | bus.update_screen;
    case (state_reg)
      IDLE: begin
        if (bus.draw_start) begin
          if (gone_reg) begin
            state_next = DONE;
          end else if (move_pending_reg) begin
            state_next        = ERASE;
            // a tick landing on this very cycle is kept for the next render
            move_pending_next = bus.update_screen;
          end else begin
            state_next = DRAW;
          end
        end
      end
      ERASE: if (sweep_last) state_next = MOVE;
      MOVE: begin
        if (pos_x_reg < STEP) begin
          gone_next  = 1'b1;
          state_next = DONE;
        end else begin
          pos_x_next = pos_x_reg - STEP;
          state_next = DRAW;
        end
      end
      DRAW: if (sweep_last) state_next = DONE;
      DONE: if (!bus.draw_start) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    sweep_start  = is_sweep(state_next) && (state_next != state_reg);
    sweep_enable = is_sweep(state_reg) && (state_next == state_reg);
  end

  // Outputs are loaded from the next-cycle view so the first pixel follows
  // the request by a single clock.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg        <= IDLE;
      pos_x_reg        <= INIT_X;
      move_pending_reg <= 1'b0;
      gone_reg         <= 1'b0;
      x_reg            <= '0;
      y_reg            <= '0;
      colour_reg       <= COL_BLACK;
      plotting_reg     <= 1'b0;
      draw_done_reg    <= 1'b0;
    end else begin
      state_reg        <= state_next;
      pos_x_reg        <= pos_x_next;
      move_pending_reg <= move_pending_next;
      gone_reg         <= gone_next;
      plotting_reg     <= is_sweep(state_next);
      draw_done_reg    <= (state_next == DONE);
      if (is_sweep(state_next)) begin
        x_reg      <= pos_x_next + {7'd0, sweep_col};
        y_reg      <= INIT_Y + {7'd0, sweep_row};
        colour_reg <= (state_next == ERASE) ? COL_BLACK : COLOUR;
      end
    end
  end

  assign bus.x          = x_reg;
  assign bus.y          = y_reg;
  assign bus.colour     = colour_reg;
  assign bus.plotting   = plotting_reg;
  assign bus.draw_done  = draw_done_reg;
  assign bus.shape_gone = {{(COORD_W-1){1'b0}}, gone_reg};
endmodule

// File: tb/tb_obstacle_drawer.sv
// Bench for obstacle_drawer: two instances (on-screen start and x=0 start)
// share stimulus; a render-level model predicts every output cycle.
module tb_obstacle_drawer;
  import game_pkg::*;

  localparam logic [3:0]  W    = 4'd4;
  localparam logic [3:0]  H    = 4'd4;
  localparam logic [10:0] Y0   = 11'd100;
  localparam logic [10:0] STEP = 11'd1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic draw_start = 1'b0;
  logic update_screen = 1'b0;

  always #5 clock = ~clock;

  obstacle_drawer_if bus_a();
  obstacle_drawer_if bus_b();

  assign bus_a.draw_start    = draw_start;
  assign bus_a.update_screen = update_screen;
  assign bus_b.draw_start    = draw_start;
  assign bus_b.update_screen = update_screen;

  obstacle_drawer #(
    .INIT_X(11'd152), .INIT_Y(Y0), .WIDTH(W), .HEIGHT(H), .STEP(STEP), .COLOUR(COL_WHITE)
  ) dut_a (
    .clock(clock), .reset(reset), .bus(bus_a)
  );

  obstacle_drawer #(
    .INIT_X(11'd0), .INIT_Y(Y0), .WIDTH(W), .HEIGHT(H), .STEP(STEP), .COLOUR(COL_WHITE)
  ) dut_b (
    .clock(clock), .reset(reset), .bus(bus_b)
  );

  logic        d_plot[2];
  logic        d_done[2];
  logic [10:0] d_x[2];
  logic [10:0] d_y[2];
  logic [10:0] d_gone[2];
  logic [2:0]  d_col[2];

  assign d_plot[0] = bus_a.plotting;
  assign d_plot[1] = bus_b.plotting;
  assign d_done[0] = bus_a.draw_done;
  assign d_done[1] = bus_b.draw_done;
  assign d_x[0]    = bus_a.x;
  assign d_x[1]    = bus_b.x;
  assign d_y[0]    = bus_a.y;
  assign d_y[1]    = bus_b.y;
  assign d_gone[0] = bus_a.shape_gone;
  assign d_gone[1] = bus_b.shape_gone;
  assign d_col[0]  = bus_a.colour;
  assign d_col[1]  = bus_b.colour;

  typedef struct packed {
    logic        plot;
    logic [10:0] x;
    logic [10:0] y;
    logic [2:0]  col;
    logic        done;
    logic        gone;
  } exp_t;

  int   init_x[2] = '{152, 0};
  exp_t cur[2];
  exp_t fifo[2][64];
  int   head[2];
  int   tail[2];
  int   m_pos[2];
  bit   m_pend[2];
  bit   m_gone[2];
  int   phase[2];   // 0 waiting for request, 1 pixel/move cycles, 2 holding done
  bit   rst_chk[2];
  bit   m_valid = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %0d, expected %0d (t=%0t)", name, inst, act, exp, $time);
    end
  endtask

  task automatic push(input int i, input bit plot, input int px, input int py,
                      input logic [2:0] col);
    fifo[i][tail[i]] = '{plot: plot, x: 11'(px), y: 11'(py), col: col, done: 1'b0, gone: 1'b0};
    tail[i]++;
  endtask

  task automatic sweep(input int i, input logic [2:0] col);
    for (int r = 0; r < int'(H); r++)
      for (int c = 0; c < int'(W); c++)
        push(i, 1'b1, m_pos[i] + c, int'(Y0) + r, col);
  endtask

  // Whole render expanded up front: erase, one idle move cycle, redraw.
  task automatic build(input int i);
    head[i] = 0;
    tail[i] = 0;
    if (m_gone[i]) begin
      m_pend[i] = m_pend[i] | update_screen;
    end else if (m_pend[i]) begin
      m_pend[i] = update_screen;
      sweep(i, COL_BLACK);
      push(i, 1'b0, 0, 0, 3'd0);
      if (m_pos[i] < int'(STEP)) begin
        m_gone[i] = 1'b1;
      end else begin
        m_pos[i] = m_pos[i] - int'(STEP);
        sweep(i, COL_WHITE);
      end
    end else begin
      m_pend[i] = m_pend[i] | update_screen;
      sweep(i, COL_WHITE);
    end
  endtask

  function automatic exp_t status_e(input bit done, input bit gone);
    return '{plot: 1'b0, x: 11'd0, y: 11'd0, col: 3'd0, done: done, gone: gone};
  endfunction

  task automatic advance(input int i);
    if (reset) begin
      cur[i]     = '0;
      phase[i]   = 0;
      head[i]    = 0;
      tail[i]    = 0;
      m_pos[i]   = init_x[i];
      m_pend[i]  = 1'b0;
      m_gone[i]  = 1'b0;
      rst_chk[i] = 1'b1;
    end else begin
      rst_chk[i] = 1'b0;
      if (phase[i] == 0) begin
        if (draw_start) begin
          build(i);
          phase[i] = 1;
        end else begin
          m_pend[i] = m_pend[i] | update_screen;
          cur[i]    = status_e(1'b0, m_gone[i]);
        end
      end else begin
        m_pend[i] = m_pend[i] | update_screen;
      end
      if (phase[i] == 1) begin
        if (head[i] != tail[i]) begin
          cur[i] = fifo[i][head[i]];
          head[i]++;
        end else begin
          cur[i]   = status_e(1'b1, m_gone[i]);
          phase[i] = 2;
        end
      end else if (phase[i] == 2) begin
        if (!draw_start) begin
          cur[i]   = status_e(1'b0, m_gone[i]);
          phase[i] = 0;
        end else begin
          cur[i] = status_e(1'b1, m_gone[i]);
        end
      end
    end
  endtask

  // Per-cycle compare on the falling edge, then step the model with the
  // inputs the next rising edge will sample.
  initial begin
    forever begin
      @(negedge clock);
      for (int i = 0; i < 2; i++) begin
        if (m_valid) begin
          check("plotting", i, 32'(d_plot[i]), 32'(cur[i].plot));
          check("draw_done", i, 32'(d_done[i]), 32'(cur[i].done));
          check("shape_gone", i, 32'(d_gone[i]), 32'(cur[i].gone));
          if (cur[i].plot || rst_chk[i]) begin
            check("x", i, 32'(d_x[i]), 32'(cur[i].x));
            check("y", i, 32'(d_y[i]), 32'(cur[i].y));
            check("colour", i, 32'(d_col[i]), 32'(cur[i].col));
          end
        end
        advance(i);
      end
      if (reset) m_valid = 1'b1;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_tick();
    update_screen = 1'b1;
    step();
    update_screen = 1'b0;
    step();
  endtask

  // Raises draw_start (cycle 0) and measures, per instance, the cycle of the
  // first draw_done, pixel count and first white x. Leaves draw_start high.
  task automatic render(input bit tick0, output int lat_a, output int npix_a,
                        output int wx0_a, output int lat_b, output int npix_b);
    lat_a = -1; lat_b = -1; npix_a = 0; npix_b = 0; wx0_a = -1;
    draw_start    = 1'b1;
    update_screen = tick0;
    for (int k = 1; k <= 100; k++) begin
      step();
      update_screen = 1'b0;
      if (lat_a < 0) begin
        if (bus_a.plotting) begin
          npix_a++;
          if (bus_a.colour == COL_WHITE && wx0_a < 0) wx0_a = int'(bus_a.x);
        end
        if (bus_a.draw_done) lat_a = k;
      end
      if (lat_b < 0) begin
        if (bus_b.plotting) npix_b++;
        if (bus_b.draw_done) lat_b = k;
      end
      if (lat_a >= 0 && lat_b >= 0) break;
    end
    check("render_completed", 0, 32'(lat_a >= 0 && lat_b >= 0), 32'd1);
  endtask

  task automatic end_render();
    draw_start = 1'b0;
    step();
    step();
  endtask

  int la, na, wa, lb, nb;

  initial begin
    reset = 1'b1;
    step();
    step();
    check("reset_plotting", 0, 32'(bus_a.plotting), 32'd0);
    check("reset_x", 0, 32'(bus_a.x), 32'd0);
    reset = 1'b0;
    step();

    // plain render, then hold draw_start until cycle 20
    render(1'b0, la, na, wa, lb, nb);
    check("t1_latency", 0, 32'(la), 32'd17);
    check("t1_pixels", 0, 32'(na), 32'd16);
    check("t1_first_x", 0, 32'(wa), 32'd152);
    check("t1_latency", 1, 32'(lb), 32'd17);
    repeat (3) step();
    check("t1_done_held", 0, 32'(bus_a.draw_done), 32'd1);
    draw_start = 1'b0;
    step();
    check("t1_done_drop", 0, 32'(bus_a.draw_done), 32'd0);
    step();

    // one move: instance b leaves the screen after its erase
    pulse_tick();
    render(1'b0, la, na, wa, lb, nb);
    check("t2_latency", 0, 32'(la), 32'd34);
    check("t2_pixels", 0, 32'(na), 32'd32);
    check("t2_first_x", 0, 32'(wa), 32'd151);
    check("t2_latency", 1, 32'(lb), 32'd18);
    check("t2_pixels", 1, 32'(nb), 32'd16);
    check("t2_gone", 1, 32'(bus_b.shape_gone), 32'd1);
    end_render();

    // two ticks saturate to one move; gone instance finishes immediately
    pulse_tick();
    pulse_tick();
    render(1'b0, la, na, wa, lb, nb);
    check("t3_latency", 0, 32'(la), 32'd34);
    check("t3_first_x", 0, 32'(wa), 32'd150);
    check("t3_latency", 1, 32'(lb), 32'd1);
    check("t3_pixels", 1, 32'(nb), 32'd0);
    end_render();

    // reset on the fifth drawn pixel
    draw_start = 1'b1;
    repeat (5) step();
    check("t4_pix5_plot", 0, 32'(bus_a.plotting), 32'd1);
    check("t4_pix5_y", 0, 32'(bus_a.y), 32'd101);
    reset      = 1'b1;
    draw_start = 1'b0;
    step();
    check("t4_rst_plot", 0, 32'(bus_a.plotting), 32'd0);
    check("t4_rst_done", 0, 32'(bus_a.draw_done), 32'd0);
    check("t4_rst_gone", 1, 32'(bus_b.shape_gone), 32'd0);
    reset = 1'b0;
    step();
    render(1'b0, la, na, wa, lb, nb);
    check("t4_latency", 0, 32'(la), 32'd17);
    check("t4_first_x", 0, 32'(wa), 32'd152);
    end_render();

    // tick on the cycle the erase begins survives into the next render
    pulse_tick();
    render(1'b1, la, na, wa, lb, nb);
    check("t5_latency", 0, 32'(la), 32'd34);
    check("t5_first_x", 0, 32'(wa), 32'd151);
    end_render();
    render(1'b0, la, na, wa, lb, nb);
    check("t5_again_latency", 0, 32'(la), 32'd34);
    check("t5_again_first_x", 0, 32'(wa), 32'd150);
    end_render();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
